// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART controller: register offsets, CON bit map, TX FSM states.
// The RX FIFO depth is only used when UART_RX_FIFO_EN is defined.
package uart_ctrl_pkg;

    localparam logic [31:0] TXD_OFS = 32'h0;
    localparam logic [31:0] RXD_OFS = 32'h4;
    localparam logic [31:0] CON_OFS = 32'h8;

    localparam int CON_TX_IRQ_EN = 0;
    localparam int CON_RX_IRQ_EN = 1;
    localparam int CON_RX_DONE   = 2;
    localparam int CON_TX_DONE   = 3;
    localparam int CON_TX_BUSY   = 4;
    localparam int CON_OVERRUN   = 5;

    localparam int RX_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } tx_state_e;

    function automatic logic [31:0] con_pack(input logic [1:0] irq_en, input logic rx_done,
                                             input logic tx_done, input logic tx_busy,
                                             input logic overrun);
        logic [31:0] w;
        w = '0;
        w[CON_TX_IRQ_EN] = irq_en[0];
        w[CON_RX_IRQ_EN] = irq_en[1];
        w[CON_RX_DONE]   = rx_done;
        w[CON_TX_DONE]   = tx_done;
        w[CON_TX_BUSY]   = tx_busy;
        w[CON_OVERRUN]   = overrun;
        return w;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider producing a one-cycle br_tick_16 enable every DIV clocks.
module uart_baud_gen #(
    parameter int unsigned DIV = 651
) (
    input  logic clk,
    input  logic reset,
    output logic br_tick_16
);

    logic [15:0] cnt_q, cnt_d;
    logic        tick;

    always_comb begin
        tick  = (cnt_q == 16'(DIV - 1));
        cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    end

    assign br_tick_16 = tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: TXD/RXD/CON registers, TX request handshake, RX capture, irq.
// Define UART_RX_FIFO_EN to back RXD with a 4-entry receive FIFO instead of a single register.
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD      = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] rdata,
    output logic        br_tick_16,
    input  logic [7:0]  rx_data,
    input  logic        rx_status,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_status,
    output logic        irq
);

    localparam int unsigned BR_DIV = CLK_FREQ / (BAUD * 16);

    uart_baud_gen #(.DIV(BR_DIV)) u_baud_gen (
        .clk        (clk),
        .reset      (reset),
        .br_tick_16 (br_tick_16)
    );

    logic sel_txd, sel_rxd, sel_con;
    logic wr_txd, wr_con, rd_con;

    assign sel_txd = (addr == BASE_ADDR + TXD_OFS);
    assign sel_rxd = (addr == BASE_ADDR + RXD_OFS);
    assign sel_con = (addr == BASE_ADDR + CON_OFS);
    assign wr_txd  = mem_write & sel_txd;
    assign wr_con  = mem_write & sel_con;
    assign rd_con  = mem_read & sel_con;

    logic        rx_status_dly_q, rx_rise;
    logic [1:0]  irq_en_q, irq_en_d;
    logic        tx_done_q, tx_done_d, tx_done_set;
    logic        overrun_q, overrun_d, ovr_set;
    logic        irq_q, irq_d;
    tx_state_e   state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        rx_done;
    logic [7:0]  rxd_val;
    logic [31:0] con_word;
    logic        unused_wdata;

    assign rx_rise      = rx_status & ~rx_status_dly_q;
    assign unused_wdata = ^wdata[31:8];

`ifdef UART_RX_FIFO_EN
    logic       rd_rxd, fifo_empty, fifo_full, push, pop;
    logic [7:0] fifo_mem [RX_FIFO_DEPTH];
    logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;

    assign rd_rxd = mem_read & sel_rxd;

    // A full FIFO still accepts a byte when the same cycle pops the head.
    always_comb begin
        fifo_empty = (count_q == 3'd0);
        fifo_full  = (count_q == 3'(RX_FIFO_DEPTH));
        pop        = rd_rxd & ~fifo_empty;
        push       = rx_rise & (~fifo_full | pop);
        ovr_set    = rx_rise & fifo_full & ~pop;
        wr_ptr_d   = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d    = count_q + {2'b00, push} - {2'b00, pop};
        rx_done    = ~fifo_empty;
        rxd_val    = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    logic [7:0] rxd_q, rxd_d;
    logic       rx_done_q, rx_done_d;

    // A new byte always overwrites RXD; overrun only records that the old one was unread.
    always_comb begin
        ovr_set   = rx_rise & rx_done_q;
        rxd_d     = rx_rise ? rx_data : rxd_q;
        rx_done_d = rx_rise | (rx_done_q & ~rd_con);
        rx_done   = rx_done_q;
        rxd_val   = rxd_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_q     <= '0;
            rx_done_q <= 1'b0;
        end else begin
            rxd_q     <= rxd_d;
            rx_done_q <= rx_done_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_done_set = 1'b0;
        tx_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_txd) begin
                    tx_data_d = wdata[7:0];
                    if (tx_status) begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                tx_en = 1'b1;
                if (!tx_status) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (tx_status) begin
                    tx_done_set = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flag sets take priority over the clear caused by a CON read in the same cycle.
    always_comb begin
        irq_en_d  = wr_con ? wdata[1:0] : irq_en_q;
        tx_done_d = tx_done_set | (tx_done_q & ~rd_con);
        overrun_d = ovr_set | (overrun_q & ~rd_con);
        irq_d     = (irq_en_q[0] & tx_done_q) | (irq_en_q[1] & rx_done);
        con_word  = con_pack(irq_en_q, rx_done, tx_done_q, state_q != IDLE, overrun_q);
    end

    always_comb begin
        rdata = '0;
        if (mem_read) begin
            if (sel_txd) begin
                rdata = {24'h0, tx_data_q};
            end else if (sel_rxd) begin
                rdata = {24'h0, rxd_val};
            end else if (sel_con) begin
                rdata = con_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_status_dly_q <= 1'b0;
            irq_en_q        <= '0;
            tx_done_q       <= 1'b0;
            overrun_q       <= 1'b0;
            irq_q           <= 1'b0;
            state_q         <= IDLE;
            tx_data_q       <= '0;
        end else begin
            rx_status_dly_q <= rx_status;
            irq_en_q        <= irq_en_d;
            tx_done_q       <= tx_done_d;
            overrun_q       <= overrun_d;
            irq_q           <= irq_d;
            state_q         <= state_d;
            tx_data_q       <= tx_data_d;
        end
    end

    assign tx_data = tx_data_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl; RX bytes and TX requests are queued as expected results.
// Also covers the UART_RX_FIFO_EN build when that macro is defined for both files.
module tb_uart_ctrl;

    localparam int unsigned CLK_FREQ = 614400;   // with BAUD=9600 gives a divide-by-4 tick
    localparam int unsigned BAUD     = 9600;
    localparam logic [31:0] BASE     = 32'h40000018;
    localparam logic [31:0] TXD_A    = BASE;
    localparam logic [31:0] RXD_A    = BASE + 32'h4;
    localparam logic [31:0] CON_A    = BASE + 32'h8;
`ifdef UART_RX_FIFO_EN
    localparam bit FIFO_MODE = 1'b1;
`else
    localparam bit FIFO_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        mem_read, mem_write;
    logic        br_tick_16;
    logic [7:0]  rx_data, tx_data;
    logic        rx_status, tx_en, tx_status, irq;

    uart_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .wdata      (wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .rdata      (rdata),
        .br_tick_16 (br_tick_16),
        .rx_data    (rx_data),
        .rx_status  (rx_status),
        .tx_data    (tx_data),
        .tx_en      (tx_en),
        .tx_status  (tx_status),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic       m_rx_done, m_tx_done, m_ovr, m_busy;
    logic [1:0] m_en;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic m_rxd_flag();
        return FIFO_MODE ? (rxq.size() != 0) : m_rx_done;
    endfunction

    function automatic logic [31:0] m_con();
        return {26'h0, m_ovr, m_busy, m_tx_done, m_rxd_flag(), m_en};
    endfunction

    function automatic logic m_irq();
        return (m_en[0] & m_tx_done) | (m_en[1] & m_rxd_flag());
    endfunction

    task automatic model_rx(input logic [7:0] b);
        if (FIFO_MODE) begin
            if (rxq.size() >= 4) m_ovr = 1'b1;
            else rxq.push_back(b);
        end else begin
            if (m_rx_done) m_ovr = 1'b1;
            rxq.delete();
            rxq.push_back(b);
            m_rx_done = 1'b1;
        end
    endtask

    task automatic model_con_read();
        m_ovr     = 1'b0;
        m_tx_done = 1'b0;
        if (!FIFO_MODE) m_rx_done = 1'b0;
    endtask

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        m_rx_done = 1'b0;
        m_tx_done = 1'b0;
        m_ovr     = 1'b0;
        m_busy    = 1'b0;
        m_en      = 2'b00;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        wdata     = d;
        mem_write = 1'b1;
        $display("[%0t] WR addr=0x%08h data=0x%08h", $time, a, d);
        tick();
        mem_write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr     = a;
        mem_read = 1'b1;
        #1;
        d = rdata;
        $display("[%0t] RD addr=0x%08h data=0x%08h", $time, a, d);
        tick();
        mem_read = 1'b0;
    endtask

    task automatic read_con(input string tag);
        logic [31:0] d;
        bus_read(CON_A, d);
        check_val(tag, d, m_con());
        model_con_read();
    endtask

    task automatic read_rxd(input string tag);
        logic [31:0] d;
        logic [7:0]  exp;
        bus_read(RXD_A, d);
        exp = 8'h00;
        if (rxq.size() != 0) begin
            exp = rxq[0];
            if (FIFO_MODE) void'(rxq.pop_front());
        end
        check_val(tag, d, {24'h0, exp});
    endtask

    task automatic rx_pulse(input logic [7:0] b, input int len);
        rx_data   = b;
        rx_status = 1'b1;
        model_rx(b);
        $display("[%0t] RX byte=0x%02h", $time, b);
        repeat (len) tick();
        rx_status = 1'b0;
        repeat (3) tick();
    endtask

    task automatic tx_expect(input string tag);
        if (txq.size() == 0) begin
            check_val({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            check_val(tag, {24'h0, tx_data}, {24'h0, txq.pop_front()});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        reset     = 1'b1;
        addr      = '0;
        wdata     = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        rx_data   = '0;
        rx_status = 1'b0;
        tx_status = 1'b1;
        model_reset();

        // Reset state and divider cadence
        repeat (2) tick();
        check_val("rst_tx_en", {31'h0, tx_en}, 32'd0);
        check_val("rst_tx_data", {24'h0, tx_data}, 32'd0);
        check_val("rst_tick", {31'h0, br_tick_16}, 32'd0);
        check_val("rst_irq", {31'h0, irq}, 32'd0);
        check_val("rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check_val($sformatf("br_tick_%0d", k), {31'h0, br_tick_16}, {31'h0, (k % 4) == 3});
        end

        // Single RX byte, read-clear of rx_done
        rx_pulse(8'hA5, 64);
        read_rxd("rx_single_rxd");
        read_con("rx_single_con1");
        read_con("rx_single_con2");
        check_val("rx_single_irq", {31'h0, irq}, 32'd0);

        // Back-to-back bytes without a CON read
        rx_pulse(8'h11, 4);
        rx_pulse(8'h22, 4);
        read_rxd("ovr_rxd");
        rx_pulse(8'h33, 4);
        read_con("ovr_con");
        read_con("ovr_con_clr");

        // Unmapped and idle accesses
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
        bus_read(BASE + 32'hC, d);
        check_val("unmapped_hi", d, 32'd0);
        bus_read(BASE - 32'h4, d);
        check_val("unmapped_lo", d, 32'd0);
        addr = CON_A;
        #1;
        check_val("no_read_rdata", rdata, 32'd0);
        read_con("unmapped_con");

        // TX handshake
        tx_status = 1'b1;
        txq.push_back(8'h5A);
        m_busy = 1'b1;
        bus_write(TXD_A, 32'h0000_005A);
        check_val("tx_req_en", {31'h0, tx_en}, 32'd1);
        tx_expect("tx_req_data");
        repeat (2) tick();
        check_val("tx_req_hold", {31'h0, tx_en}, 32'd1);
        read_con("tx_busy_con");
        tx_status = 1'b0;
        tick();
        check_val("tx_busy_en", {31'h0, tx_en}, 32'd0);
        bus_write(TXD_A, 32'h0000_0077);
        check_val("tx_busy_ignore", {24'h0, tx_data}, 32'h5A);
        repeat (17) tick();
        tx_status = 1'b1;
        tick();
        m_busy    = 1'b0;
        m_tx_done = 1'b1;
        read_con("tx_done_con");
        check_val("tx_done_en", {31'h0, tx_en}, 32'd0);

        // TXD write while the transmitter reports busy: latch only, no request
        tx_status = 1'b0;
        bus_write(TXD_A, 32'h0000_003C);
        tick();
        check_val("tx_norq_en", {31'h0, tx_en}, 32'd0);
        check_val("tx_norq_data", {24'h0, tx_data}, 32'h3C);
        read_con("tx_norq_con");
        tx_status = 1'b1;
        tick();
        check_val("tx_norq_en2", {31'h0, tx_en}, 32'd0);

        // IRQ enable and read-clear race against an RX event
`ifdef UART_RX_FIFO_EN
        repeat (rxq.size()) read_rxd("drain_rxd");
`endif
        bus_write(CON_A, 32'h0000_0003);
        m_en = 2'b11;
        tick();
        check_val("irq_pre", {31'h0, irq}, {31'h0, m_irq()});
        rx_data   = 8'hC3;
        addr      = CON_A;
        mem_read  = 1'b1;
        rx_status = 1'b1;
        #1;
        d = rdata;
        $display("[%0t] RD addr=0x%08h data=0x%08h (with RX event)", $time, CON_A, d);
        check_val("race_con", d, m_con());
        model_con_read();
        model_rx(8'hC3);
        tick();
        mem_read = 1'b0;
        check_val("irq_lat0", {31'h0, irq}, 32'd0);
        tick();
        check_val("irq_lat1", {31'h0, irq}, 32'd1);
        repeat (2) tick();
        rx_status = 1'b0;
        read_con("race_after_con");
        tick();
        check_val("irq_after_clr", {31'h0, irq}, {31'h0, m_irq()});
        read_rxd("race_rxd");
        tick();
        check_val("irq_after_rxd", {31'h0, irq}, {31'h0, m_irq()});

`ifdef UART_RX_FIFO_EN
        // FIFO fill past capacity, then drain
        bus_write(CON_A, 32'h0);
        m_en = 2'b00;
        for (int i = 1; i <= 5; i++) rx_pulse(8'(i), 4);
        read_con("fifo_full_con");
        for (int i = 0; i < 4; i++) read_rxd($sformatf("fifo_rxd_%0d", i));
        read_con("fifo_empty_con");
        read_rxd("fifo_empty_rxd");
`endif

        // Reset in the middle of a transfer
        tx_status = 1'b1;
        txq.push_back(8'h99);
        m_busy = 1'b1;
        bus_write(TXD_A, 32'h0000_0099);
        check_val("mid_tx_en", {31'h0, tx_en}, 32'd1);
        tx_expect("mid_tx_data");
        rx_pulse(8'hEE, 4);
        reset = 1'b1;
        tick();
        check_val("mid_rst_en", {31'h0, tx_en}, 32'd0);
        check_val("mid_rst_irq", {31'h0, irq}, 32'd0);
        reset = 1'b0;
        model_reset();
        read_con("mid_rst_con");
        read_rxd("mid_rst_rxd");
        check_val("mid_rst_txdata", {24'h0, tx_data}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
